mem_arbiter: RTL and testbench

Single-port memory arbiter that shares one unified backing memory between the pipeline's instruction-fetch port and its data (load/store) port. It sits between the IF/M stages and the memory, serialising requests through a four-state FSM with a req/ack handshake. Data accesses have fixed priority; a starvation guard ensures fetch progress. A watchdog terminates accesses the memory never answers. The pipeline holds its stage registers while a request is outstanding.

---
 rtl/arb_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 50 +++++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants for the fetch/data memory arbiter: FSM encoding, grant ids, op codes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package arb_pkg;

    // FSM encoding, kept as plain 2-bit constants for compatibility with older blocks
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // Grant identifiers; also the encoding of the last-grant register
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    // Memory op code used for every instruction fetch
    localparam logic [2:0] OP_WORD = 3'b010;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data request ports.
// Latency: zero (pure combinational).
// Backpressure: none; the caller only samples the result while the FSM is idle.
//
// Ports: i_req/d_req requests, last_gnt previous winner, starve_sat fetch-starvation flag,
//        gnt_vld some request present, gnt winner (GNT_I / GNT_D).
// Build option: ARB_RR_EN selects strict alternation on contention instead of
//        data priority with a starvation guard.
module mem_arb_pick
    import arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_gnt,
    input  logic starve_sat,
    output logic gnt_vld,
    output logic gnt
);

    assign gnt_vld = i_req | d_req;

`ifdef ARB_RR_EN
    // Starvation is impossible under alternation, so the flag is ignored.
    logic unused_starve_sat;
    assign unused_starve_sat = starve_sat;

    always_comb begin
        gnt = GNT_I;
        if (i_req && d_req) begin
            gnt = ~last_gnt;
        end else if (d_req) begin
            gnt = GNT_D;
        end
    end
`else
    // Fixed data priority; history only matters through the starvation flag.
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;

    always_comb begin
        gnt = GNT_I;
        if (i_req && starve_sat) begin
            gnt = GNT_I;
        end else if (d_req) begin
            gnt = GNT_D;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter sharing one memory between instruction fetch and data access.
// Latency: request sampled in IDLE (cycle 0), m_en cycle 1, ack cycle 3 at best; TIMEOUT+2 on no response.
// Backpressure: requesters hold req and fields stable until their ack; one access in flight at a time.
//
// Ports: clk, clr (sync active-low reset); i_req/i_addr -> i_ack/i_rdata fetch port;
//        d_req/d_we/d_op/d_addr/d_wdata -> d_ack/d_rdata data port; ack_err flags a timed-out access;
//        m_en/m_we/m_op/m_addr/m_wdata/m_rdata/m_valid memory side; busy = FSM not idle.
// Build option: ARB_RR_EN replaces data priority + starvation counter with strict alternation.
module mem_arbiter
    import arb_pkg::*;
#(
`ifndef ARB_RR_EN
    parameter int STARVE_MAX = 4,
`endif
    parameter int TIMEOUT    = 16
)(
    input  logic        clk,
    input  logic        clr,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_op,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        ack_err,
    output logic        m_en,
    output logic        m_we,
    output logic [2:0]  m_op,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_valid,
    output logic        busy
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic       gnt_q;      // winner of the current access, and last grant once idle
    logic       we_q;
    logic       err_q;
    logic [7:0] wcnt;
    logic       pick_vld;
    logic       pick_gnt;
    logic       starve_sat;

    mem_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_gnt   (gnt_q),
        .starve_sat (starve_sat),
        .gnt_vld    (pick_vld),
        .gnt        (pick_gnt)
    );

`ifdef ARB_RR_EN
    assign starve_sat = 1'b0;
`else
    localparam logic [3:0] STARVE_SAT = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;

    // Counts data wins that bypassed a waiting fetch; any fetch grant restarts the count.
    always_ff @(posedge clk) begin
        if (!clr) begin
            starve_cnt <= '0;
        end else if (state == S_IDLE && pick_vld) begin
            if (pick_gnt == GNT_I) begin
                starve_cnt <= '0;
            end else if (i_req && starve_cnt != STARVE_SAT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    assign starve_sat = (starve_cnt == STARVE_SAT);
`endif

    always_ff @(posedge clk) begin
        if (!clr) begin
            state   <= S_IDLE;
            gnt_q   <= GNT_I;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            wcnt    <= '0;
            m_op    <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        gnt_q <= pick_gnt;
                        if (pick_gnt == GNT_D) begin
                            m_addr  <= d_addr;
                            m_op    <= d_op;
                            we_q    <= d_we;
                            m_wdata <= d_wdata;
                        end else begin
                            m_addr  <= i_addr;
                            m_op    <= OP_WORD;
                            we_q    <= 1'b0;
                        end
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wcnt  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A response arriving in the last allowed cycle still counts as success.
                    if (m_valid) begin
                        err_q <= 1'b0;
                        state <= S_RESP;
                        if (gnt_q == GNT_I) begin
                            i_rdata <= m_rdata;
                        end else if (!we_q) begin
                            d_rdata <= m_rdata;
                        end
                    end else if (wcnt == WAIT_LAST) begin
                        err_q <= 1'b1;
                        state <= S_RESP;
                        if (gnt_q == GNT_I) begin
                            i_rdata <= '0;
                        end else if (!we_q) begin
                            d_rdata <= '0;
                        end
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = (state != S_IDLE);
    assign m_en    = (state == S_ISSUE);
    assign m_we    = m_en & we_q;
    assign i_ack   = (state == S_RESP) && (gnt_q == GNT_I);
    assign d_ack   = (state == S_RESP) && (gnt_q == GNT_D);
    assign ack_err = (state == S_RESP) && err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus randomized request mixes
// compared against a transaction-level model of grants, latency and read data.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 16;
    localparam logic [2:0] WORD_OP = 3'b010;

    logic        clk = 1'b0;
    logic        clr;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_op;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        ack_err;
    logic        m_en;
    logic        m_we;
    logic [2:0]  m_op;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_valid;
    logic        busy;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk     (clk),
        .clr     (clr),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_ack   (i_ack),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_op    (d_op),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_ack   (d_ack),
        .d_rdata (d_rdata),
        .ack_err (ack_err),
        .m_en    (m_en),
        .m_we    (m_we),
        .m_op    (m_op),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_valid (m_valid),
        .busy    (busy)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int          mdl_starve;
    logic        mdl_last_d;
    logic [31:0] exp_i_rdata;
    logic [31:0] exp_d_rdata;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Returns 1 when the data port should win.
    function automatic logic mdl_pick(input logic ir, input logic dr);
`ifdef ARB_RR_EN
        if (ir && dr) return !mdl_last_d;
        return dr;
`else
        if (ir && mdl_starve == STARVE_MAX) return 1'b0;
        return dr;
`endif
    endfunction

    task automatic mdl_grant(input logic ir, input logic win_d);
        if (win_d) begin
            if (ir && mdl_starve < STARVE_MAX) mdl_starve++;
        end else begin
            mdl_starve = 0;
        end
        mdl_last_d = win_d;
    endtask

    task automatic mdl_reset();
        mdl_starve  = 0;
        mdl_last_d  = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b0; i_req = 1'b0; d_req = 1'b0; m_valid = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        mdl_reset();
    endtask

    // One complete access. Starts expecting the DUT idle at the next falling edge,
    // returns at the falling edge inside the ack cycle.
    task automatic run_access(input logic ir, input logic dr, input logic we, input logic [2:0] op,
                              input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dw,
                              input logic [31:0] rsp, input int delay, input logic to,
                              output logic won_d);
        logic        w;
        logic [31:0] rd;
        int          ack_cyc;
        int          exp_cyc;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        i_req = ir; i_addr = ia;
        d_req = dr; d_we = we; d_op = op; d_addr = da; d_wdata = dw;
        w = mdl_pick(ir, dr);
        mdl_grant(ir, w);
        won_d   = w;
        exp_cyc = to ? TIMEOUT + 2 : 3 + delay;
        ack_cyc = -1;
        rd      = '0;
        for (int cyc = 1; cyc <= TIMEOUT + 4; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                chk("issue_en", 32'(m_en), 32'd1);
                chk("issue_we", 32'(m_we), 32'(w & we));
                chk("issue_addr", m_addr, w ? da : ia);
                chk("issue_op", 32'(m_op), 32'(w ? op : WORD_OP));
                if (w && we) chk("issue_wdata", m_wdata, dw);
            end else begin
                chk("en_once", 32'({m_en, m_we}), 32'd0);
            end
            if (i_ack || d_ack) begin
                ack_cyc = cyc;
                break;
            end
            chk("busy", 32'(busy), 32'd1);
            m_valid = (!to && cyc == 2 + delay);
            m_rdata = m_valid ? rsp : ~rsp;
            if (m_valid) rd = rsp;
        end
        m_valid = 1'b0;
        chk("ack_cycle", 32'(ack_cyc), 32'(exp_cyc));
        if (ack_cyc > 0) begin
            chk("ack_port", 32'({i_ack, d_ack}), w ? 32'd1 : 32'd2);
            chk("ack_err", 32'(ack_err), 32'(to));
            chk("busy_resp", 32'(busy), 32'd1);
            if (!w) exp_i_rdata = rd;
            else if (!we) exp_d_rdata = rd;
            chk("i_rdata", i_rdata, exp_i_rdata);
            chk("d_rdata", d_rdata, exp_d_rdata);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       w;
        logic [9:0] seq;
        logic       ir, dr, we, to;

        clr = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_op = '0;
        i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0; m_valid = 1'b0;
        mdl_reset();
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_acks", 32'({i_ack, d_ack, ack_err}), 32'd0);
        chk("rst_m_en_we", 32'({m_en, m_we}), 32'd0);
        chk("rst_m_op", 32'(m_op), 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        clr = 1'b1;

        // Single load, fastest response
        run_access(1'b0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h100, 32'h0, 32'hCAFEF00D, 0, 1'b0, w);
        chk("load_d_rdata", d_rdata, 32'hCAFEF00D);

        // Store leaves d_rdata untouched
        run_access(1'b0, 1'b1, 1'b1, 3'b010, 32'h0, 32'h20, 32'h12345678, 32'h0BADBEEF, 1, 1'b0, w);
        chk("store_d_rdata", d_rdata, 32'hCAFEF00D);

        // Continuous contention from reset
        do_reset();
        seq = '0;
        for (int k = 0; k < 10; k++) begin
            run_access(1'b1, 1'b1, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                       $urandom | 32'h1, $urandom_range(0, 1), 1'b0, w);
            seq = {seq[8:0], w};
        end
`ifdef ARB_RR_EN
        chk("contention_seq", 32'(seq), 32'(10'b1010101010));
`else
        chk("contention_seq", 32'(seq), 32'(10'b1111011110));
`endif

        // Fetch with no memory response
        run_access(1'b1, 1'b0, 1'b0, 3'b000, 32'h4000, 32'h0, 32'h0, 32'h0, 0, 1'b1, w);
        chk("timeout_i_rdata", i_rdata, 32'd0);

        // Reset in WAIT followed by a stray response
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_op = 3'b010; d_addr = 32'h300;
        @(negedge clk);
        chk("rstw_issue", 32'(m_en), 32'd1);
        @(negedge clk);
        chk("rstw_wait_busy", 32'(busy), 32'd1);
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1; d_req = 1'b0; m_valid = 1'b1; m_rdata = 32'h5555AAAA;
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_acks", 32'({i_ack, d_ack, m_en}), 32'd0);
        @(negedge clk);
        m_valid = 1'b0;
        chk("rstw_busy2", 32'(busy), 32'd0);
        chk("rstw_acks2", 32'({i_ack, d_ack, ack_err}), 32'd0);
        mdl_reset();
        chk("rstw_d_rdata", d_rdata, 32'd0);
        chk("rstw_i_rdata", i_rdata, 32'd0);
        run_access(1'b0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h300, 32'h0, 32'h600DF00D, 2, 1'b0, w);

        // Response with nothing outstanding
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0; m_valid = 1'b1; m_rdata = 32'hDEADBEEF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("late_busy", 32'(busy), 32'd0);
            chk("late_acks", 32'({i_ack, d_ack, ack_err, m_en}), 32'd0);
        end
        m_valid = 1'b0;
        chk("late_i_rdata", i_rdata, exp_i_rdata);
        chk("late_d_rdata", d_rdata, exp_d_rdata);

        // Randomized request mixes
        for (int k = 0; k < 150; k++) begin
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (!ir && !dr) ir = 1'b1;
            we = 1'($urandom_range(0, 1));
            to = ($urandom_range(0, 19) == 0) && !(dr && we);
            run_access(ir, dr, we, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                       $urandom, $urandom_range(0, 3), to, w);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
